// File: rtl/i2c_target_regs.sv
// i2c_target_regs: system-clocked I2C target with a four-entry register map.
// SCL/SDA are oversampled on clk, START/STOP and SCL edges are found from the
// synchronized levels, and SDA is only ever pulled low through sda_oe.
module i2c_target_regs #(
    parameter logic [6:0] ADDR     = 7'h2A,
    parameter logic [7:0] RST_CTRL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic       wr_strobe,
    output logic [1:0] wr_addr,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK
    } state_t;

    // Bit 0 is the first synchronizer stage, bit 1 the synchronized level,
    // bit 2 the previous synchronized level used for edge detection.
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] reg0_q, reg0_d;
    logic [7:0] reg1_q, reg1_d;
    logic [7:0] reg2_q, reg2_d;
    logic       ack_phase_q, ack_phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [1:0] wr_addr_q, wr_addr_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, scl_high;
    logic       start_det, stop_det;
    logic       sda_bit;
    logic       last_bit;
    logic [7:0] byte_in;
    logic [7:0] rd_data;

    // Shift the raw pin levels into the synchronizer chains.
    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
    end

    // Synchronizers reset to the idle-bus level so no false edge follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    // Decode bus events from synchronized levels and select the read source.
    always_comb begin
        scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
        scl_high  = scl_sync_q[1] & scl_sync_q[2];
        start_det = scl_high & ~sda_sync_q[1] & sda_sync_q[2];
        stop_det  = scl_high & sda_sync_q[1] & ~sda_sync_q[2];
        sda_bit   = sda_sync_q[1];
        last_bit  = (bit_cnt_q == 4'd7);
        byte_in   = {shift_q[6:0], sda_bit};
        case (ptr_q)
            2'd0:    rd_data = reg0_q;
            2'd1:    rd_data = reg1_q;
            2'd2:    rd_data = reg2_q;
            default: rd_data = status_in;
        endcase
    end

    // Protocol state machine: STOP/START override any bit-level activity.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        reg0_d      = reg0_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        ack_phase_d = ack_phase_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        busy_d      = busy_q;

        if (stop_det) begin
            state_d     = S_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
        end else if (start_det) begin
            state_d     = S_ADDR;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_d   = 4'd0;
                            ack_phase_d = 1'b0;
                            if (byte_in[7:1] == ADDR) begin
                                state_d = S_ADDR_ACK;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end

                S_PTR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_d   = 4'd0;
                            ack_phase_d = 1'b0;
                            ptr_d       = byte_in[1:0];
                            state_d     = S_PTR_ACK;
                        end
                    end
                end

                S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_d   = 4'd0;
                            ack_phase_d = 1'b0;
                            case (ptr_q)
                                2'd0:    reg0_d = byte_in;
                                2'd1:    reg1_d = byte_in;
                                2'd2:    reg2_d = byte_in;
                                default: begin
                                end
                            endcase
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            ptr_d       = ptr_q + 2'd1;
                            state_d     = S_WDATA_ACK;
                        end
                    end
                end

                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 4'd0;
                            sda_oe_d    = 1'b0;
                            if (state_q == S_ADDR_ACK && shift_q[0]) begin
                                state_d  = S_RDATA;
                                shift_d  = rd_data;
                                sda_oe_d = ~rd_data[7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d    = 1'b0;
                            ptr_d       = ptr_q + 2'd1;
                            bit_cnt_d   = 4'd0;
                            ack_phase_d = 1'b0;
                            state_d     = S_RDATA_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                S_RDATA_ACK: begin
                    if (!ack_phase_q) begin
                        if (scl_rise) begin
                            if (sda_bit) begin
                                state_d  = S_IDLE;
                                sda_oe_d = 1'b0;
                            end else begin
                                ack_phase_d = 1'b1;
                            end
                        end
                    end else if (scl_fall) begin
                        state_d     = S_RDATA;
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 4'd0;
                        shift_d     = rd_data;
                        sda_oe_d    = ~rd_data[7];
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and register file; reset releases SDA without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 2'd0;
            reg0_q      <= RST_CTRL;
            reg1_q      <= 8'h00;
            reg2_q      <= 8'h00;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            reg0_q      <= reg0_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            ack_phase_q <= ack_phase_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign ctrl_out  = reg0_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level I2C master driving i2c_target_regs, checked
// against a transaction-level model of the register map and pointer.
module tb_i2c_target_regs;

    localparam logic [6:0] ADDR     = 7'h2A;
    localparam logic [7:0] RST_CTRL = 8'hC3;
    localparam int         Q        = 5;
    localparam logic [7:0] AW       = {ADDR, 1'b0};
    localparam logic [7:0] AR       = {ADDR, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] status_in;
    logic [7:0] ctrl_out;
    logic       wr_strobe;
    logic [1:0] wr_addr;
    logic       busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] m_regs [4];
    logic [1:0] m_ptr;

    logic [1:0] strobe_addr_q [$];
    logic [7:0] strobe_ctrl_q [$];
    logic [7:0] rd_bytes_q [$];
    logic [7:0] wr_data [4];
    logic       oe_seen;
    logic       oe_after_nack;
    logic       busy_before_stop;

    // Open-drain bus: the line is low if either side pulls it.
    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_target_regs #(.ADDR(ADDR), .RST_CTRL(RST_CTRL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every write strobe with the ctrl_out value seen in that cycle.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_addr_q.push_back(wr_addr);
            strobe_ctrl_q.push_back(ctrl_out);
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        m_regs[0] = RST_CTRL;
        m_regs[1] = 8'h00;
        m_regs[2] = 8'h00;
        m_regs[3] = 8'h00;
        m_ptr     = 2'd0;
    endtask

    function automatic logic [7:0] model_value(input logic [1:0] idx);
        return (idx == 2'd3) ? status_in : m_regs[idx];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_in;   tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = ~b;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // START, address, pointer, n bytes from wr_data, STOP; counts ACKed bytes.
    task automatic do_write(input logic [7:0] addr_byte, input logic [7:0] p,
                            input int n, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        send_byte(addr_byte, a); if (a) acks++;
        send_byte(p, a);         if (a) acks++;
        for (int i = 0; i < n; i++) begin
            send_byte(wr_data[i], a);
            if (a) acks++;
        end
        i2c_stop();
    endtask

    // Optional pointer set plus repeated START, then read n bytes (NACK last).
    task automatic do_read(input logic with_ptr, input logic [7:0] p,
                           input int n, output int acks);
        logic       a;
        logic [7:0] d;
        acks = 0;
        rd_bytes_q.delete();
        i2c_start();
        if (with_ptr) begin
            send_byte(AW, a); if (a) acks++;
            send_byte(p, a);  if (a) acks++;
            i2c_rstart();
        end
        send_byte(AR, a); if (a) acks++;
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            rd_bytes_q.push_back(d);
        end
        oe_after_nack    = sda_oe;
        busy_before_stop = busy;
        i2c_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; status_in = 8'h00;
        tick(3);
        n_compared++;
        if (sda_oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_compared++;
        if (ctrl_out !== RST_CTRL) begin n_mismatched++; $display("[TB] FAIL reset_ctrl: got %h want %h", ctrl_out, RST_CTRL); end
        n_compared++;
        if (wr_strobe !== 1'b0 || wr_addr !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_wr: got %b/%0d want 0/0", wr_strobe, wr_addr); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick(4);
        model_reset();
    endtask

    task automatic test_write_reg0();
        logic a0, a1, a2;
        strobe_addr_q.delete(); strobe_ctrl_q.delete();
        i2c_start();
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL busy_after_start: got %b want 1", busy); end
        send_byte(AW, a0); send_byte(8'h00, a1); send_byte(8'hA5, a2);
        n_compared++;
        if ({a0, a1, a2} !== 3'b111) begin n_mismatched++; $display("[TB] FAIL wr0_acks: got %b want 111", {a0, a1, a2}); end
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL busy_mid: got %b want 1", busy); end
        i2c_stop();
        m_regs[0] = 8'hA5; m_ptr = 2'd1;
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_after_stop: got %b want 0", busy); end
        n_compared++;
        if (ctrl_out !== m_regs[0]) begin n_mismatched++; $display("[TB] FAIL wr0_ctrl: got %h want %h", ctrl_out, m_regs[0]); end
        n_compared++;
        if (strobe_addr_q.size() != 1) begin
            n_mismatched++; $display("[TB] FAIL wr0_strobes: got %0d want 1", strobe_addr_q.size());
        end else if (strobe_addr_q[0] !== 2'd0 || strobe_ctrl_q[0] !== 8'hA5) begin
            n_mismatched++; $display("[TB] FAIL wr0_strobe_val: got %0d/%h want 0/a5", strobe_addr_q[0], strobe_ctrl_q[0]);
        end
    endtask

    task automatic test_autoinc_wrap();
        int acks;
        logic [1:0] exp_addr [3];
        strobe_addr_q.delete(); strobe_ctrl_q.delete();
        wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_data[2] = 8'h33;
        m_ptr = 2'd2;
        for (int i = 0; i < 3; i++) begin
            exp_addr[i] = m_ptr;
            if (m_ptr != 2'd3) m_regs[m_ptr] = wr_data[i];
            m_ptr = m_ptr + 2'd1;
        end
        do_write(AW, 8'h02, 3, acks);
        n_compared++;
        if (acks != 5) begin n_mismatched++; $display("[TB] FAIL wrap_acks: got %0d want 5", acks); end
        n_compared++;
        if (strobe_addr_q.size() != 3) begin
            n_mismatched++; $display("[TB] FAIL wrap_strobes: got %0d want 3", strobe_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_compared++;
                if (strobe_addr_q[i] !== exp_addr[i]) begin
                    n_mismatched++; $display("[TB] FAIL wrap_addr%0d: got %0d want %0d", i, strobe_addr_q[i], exp_addr[i]);
                end
            end
        end
        n_compared++;
        if (ctrl_out !== m_regs[0]) begin n_mismatched++; $display("[TB] FAIL wrap_ctrl: got %h want %h", ctrl_out, m_regs[0]); end
    endtask

    task automatic test_read_rstart();
        int acks;
        logic [7:0] exp [2];
        status_in = 8'h5C;
        m_ptr = 2'd3;
        for (int i = 0; i < 2; i++) begin
            exp[i] = model_value(m_ptr);
            m_ptr = m_ptr + 2'd1;
        end
        do_read(1'b1, 8'h03, 2, acks);
        n_compared++;
        if (acks != 3) begin n_mismatched++; $display("[TB] FAIL rd_acks: got %0d want 3", acks); end
        for (int i = 0; i < 2; i++) begin
            n_compared++;
            if (rd_bytes_q[i] !== exp[i]) begin n_mismatched++; $display("[TB] FAIL rd_byte%0d: got %h want %h", i, rd_bytes_q[i], exp[i]); end
        end
        n_compared++;
        if (oe_after_nack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rd_oe_after_nack: got %b want 0", oe_after_nack); end
        n_compared++;
        if (busy_before_stop !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_busy: got %b want 1", busy_before_stop); end
        // Pointer survives STOP: a bare read continues from reg 1, then reg 2.
        exp[0] = model_value(m_ptr); m_ptr = m_ptr + 2'd1;
        exp[1] = model_value(m_ptr); m_ptr = m_ptr + 2'd1;
        do_read(1'b0, 8'h00, 2, acks);
        for (int i = 0; i < 2; i++) begin
            n_compared++;
            if (rd_bytes_q[i] !== exp[i]) begin n_mismatched++; $display("[TB] FAIL rd_cont%0d: got %h want %h", i, rd_bytes_q[i], exp[i]); end
        end
    endtask

    task automatic test_addr_mismatch();
        int acks;
        strobe_addr_q.delete(); strobe_ctrl_q.delete();
        oe_seen = 1'b0;
        wr_data[0] = 8'hFF;
        do_write(8'h56, 8'h00, 1, acks);
        n_compared++;
        if (acks != 0) begin n_mismatched++; $display("[TB] FAIL nomatch_acks: got %0d want 0", acks); end
        n_compared++;
        if (oe_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nomatch_oe: got %b want 0", oe_seen); end
        n_compared++;
        if (strobe_addr_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL nomatch_strobes: got %0d want 0", strobe_addr_q.size()); end
        n_compared++;
        if (ctrl_out !== m_regs[0]) begin n_mismatched++; $display("[TB] FAIL nomatch_ctrl: got %h want %h", ctrl_out, m_regs[0]); end
    endtask

    task automatic test_early_stop();
        logic a;
        int acks;
        logic [7:0] exp;
        strobe_addr_q.delete(); strobe_ctrl_q.delete();
        i2c_start();
        send_byte(AW, a);
        send_byte(8'h01, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        m_ptr = 2'd1;
        n_compared++;
        if (strobe_addr_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL early_strobes: got %0d want 0", strobe_addr_q.size()); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL early_busy: got %b want 0", busy); end
        exp = model_value(m_ptr); m_ptr = m_ptr + 2'd1;
        do_read(1'b0, 8'h00, 1, acks);
        n_compared++;
        if (acks != 1 || rd_bytes_q[0] !== exp) begin
            n_mismatched++; $display("[TB] FAIL early_readback: got ack %0d byte %h want 1 %h", acks, rd_bytes_q[0], exp);
        end
    endtask

    task automatic test_random();
        int kind, n, acks;
        logic [7:0] p;
        logic [6:0] wa;
        logic [1:0] exp_addr [4];
        logic [7:0] exp_byte [4];
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            p = 8'($urandom);
            status_in = 8'($urandom);
            strobe_addr_q.delete(); strobe_ctrl_q.delete();
            oe_seen = 1'b0;
            for (int i = 0; i < 4; i++) wr_data[i] = 8'($urandom);
            if (kind == 0) begin
                m_ptr = p[1:0];
                for (int i = 0; i < n; i++) begin
                    exp_addr[i] = m_ptr;
                    if (m_ptr != 2'd3) m_regs[m_ptr] = wr_data[i];
                    m_ptr = m_ptr + 2'd1;
                end
                do_write(AW, p, n, acks);
                n_compared++;
                if (acks != n + 2) begin n_mismatched++; $display("[TB] FAIL rnd%0d_wacks: got %0d want %0d", t, acks, n + 2); end
                n_compared++;
                if (strobe_addr_q.size() != n) begin
                    n_mismatched++; $display("[TB] FAIL rnd%0d_strobes: got %0d want %0d", t, strobe_addr_q.size(), n);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        n_compared++;
                        if (strobe_addr_q[i] !== exp_addr[i] ||
                            (exp_addr[i] == 2'd0 && strobe_ctrl_q[i] !== wr_data[i])) begin
                            n_mismatched++;
                            $display("[TB] FAIL rnd%0d_strobe%0d: got %0d/%h want %0d/%h", t, i,
                                     strobe_addr_q[i], strobe_ctrl_q[i], exp_addr[i], wr_data[i]);
                        end
                    end
                end
                n_compared++;
                if (ctrl_out !== m_regs[0]) begin n_mismatched++; $display("[TB] FAIL rnd%0d_ctrl: got %h want %h", t, ctrl_out, m_regs[0]); end
            end else if (kind == 1 || kind == 2) begin
                if (kind == 1) m_ptr = p[1:0];
                for (int i = 0; i < n; i++) begin
                    exp_byte[i] = model_value(m_ptr);
                    m_ptr = m_ptr + 2'd1;
                end
                do_read(kind == 1, p, n, acks);
                n_compared++;
                if (acks != ((kind == 1) ? 3 : 1)) begin n_mismatched++; $display("[TB] FAIL rnd%0d_racks: got %0d", t, acks); end
                for (int i = 0; i < n; i++) begin
                    n_compared++;
                    if (rd_bytes_q[i] !== exp_byte[i]) begin
                        n_mismatched++; $display("[TB] FAIL rnd%0d_rbyte%0d: got %h want %h", t, i, rd_bytes_q[i], exp_byte[i]);
                    end
                end
            end else begin
                wa = ADDR ^ 7'($urandom_range(1, 127));
                do_write({wa, 1'b0}, p, n, acks);
                n_compared++;
                if (acks != 0 || oe_seen !== 1'b0 || strobe_addr_q.size() != 0) begin
                    n_mismatched++; $display("[TB] FAIL rnd%0d_other_addr: got acks %0d oe %b strobes %0d want 0 0 0",
                                             t, acks, oe_seen, strobe_addr_q.size());
                end
            end
        end
    endtask

    task automatic test_reset_midread();
        logic a;
        int acks;
        wr_data[0] = 8'h5A;
        do_write(AW, 8'h00, 1, acks);
        m_regs[0] = 8'h5A; m_ptr = 2'd1;
        i2c_start();
        send_byte(AW, a);
        send_byte(8'h00, a);
        i2c_rstart();
        send_byte(AR, a);
        tick(2);
        n_compared++;
        if (sda_oe !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midread_driving: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (sda_oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midread_reset_oe: got %b want 0", sda_oe); end
        n_compared++;
        if (ctrl_out !== RST_CTRL || busy !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL midread_reset_regs: got %h/%b want %h/0", ctrl_out, busy, RST_CTRL);
        end
        tick(1);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        model_reset();
        do_read(1'b0, 8'h00, 1, acks);
        n_compared++;
        if (acks != 1 || rd_bytes_q[0] !== RST_CTRL) begin
            n_mismatched++; $display("[TB] FAIL post_reset_read: got ack %0d byte %h want 1 %h", acks, rd_bytes_q[0], RST_CTRL);
        end
    endtask

    initial begin
        $display("[TB] starting i2c_target_regs bench");
        test_reset();
        test_write_reg0();
        test_autoinc_wrap();
        test_read_rstart();
        test_addr_mismatch();
        test_early_stop();
        test_random();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
